data_mux_sequencer: RTL

Fabric-clock controller that drives the 4-bit `output_select` of the stream data mux. It rotates through a programmable set of enabled input channels, dwelling on each for a programmed number of orbits counted from `fc_orbitSync`. A channel switch is only committed when no output beat is stalled, and it is followed by a settle window during which `mux_hold` is asserted. Its control inputs come from the IPIF parameter registers (already in the `clk` domain); its status outputs are readable there.

---
 rtl/data_mux_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/data_mux_sequencer.sv
`timescale 1ns/1ps
// Stream data mux select sequencer. It rotates output_select over the enabled channels,
// dwells a programmed number of orbits on each, and holds the output while a switch settles.
module data_mux_sequencer #(
  parameter int N_INPUTS     = 2,
  parameter int DWELL_WIDTH  = 16,
  parameter int SETTLE_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic [15:0]             channel_mask,
  input  logic [DWELL_WIDTH-1:0]  dwell_orbits,
  input  logic [SETTLE_WIDTH-1:0] settle_cycles,
  input  logic                    fc_orbitSync,
  input  logic                    fc_linkReset,
  input  logic                    mux_out_tvalid,
  input  logic                    mux_out_tready,
  output logic [3:0]              output_select,
  output logic                    mux_hold,
  output logic                    busy,
  output logic                    no_channel,
  output logic [15:0]             switch_count
);

  // state  | meaning
  // IDLE   | stopped, select retained
  // DRAIN  | waiting for no stalled beat before committing the next channel
  // SETTLE | new channel committed, mux_hold high
  // DWELL  | counting orbits on the current channel
  typedef enum logic [1:0] {IDLE, DRAIN, SETTLE, DWELL} state_t;

  localparam logic [15:0]             IN_MASK = 16'((32'd1 << N_INPUTS) - 32'd1);
  localparam logic [DWELL_WIDTH-1:0]  D_ONE   = DWELL_WIDTH'(1);
  localparam logic [SETTLE_WIDTH-1:0] S_ONE   = SETTLE_WIDTH'(1);

  state_t                  state, state_next;
  logic [3:0]              ptr, ptr_next, sel_next, nxt_ch;
  logic                    rst_ptr, rst_ptr_next;
  logic [SETTLE_WIDTH-1:0] settle_cnt, settle_next;
  logic [DWELL_WIDTH-1:0]  orbit_cnt, orbit_next;
  logic [15:0]             swc_next, em;
  logic                    hold_next, busy_next, no_ch_next;

  // First set bit of m at or above start, wrapping modulo 16.
  function automatic logic [3:0] next_ch(input logic [15:0] m, input logic [3:0] start);
    logic [3:0] idx;
    logic       found;
    next_ch = start;
    found   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = start + 4'(i);
      if (!found && m[idx]) begin
        next_ch = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign em     = channel_mask & IN_MASK;
  assign nxt_ch = next_ch(em, rst_ptr ? 4'd0 : ptr + 4'd1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      ptr           <= 4'd15;
      output_select <= 4'd0;
      rst_ptr       <= 1'b0;
      settle_cnt    <= '0;
      orbit_cnt     <= '0;
      switch_count  <= 16'd0;
      mux_hold      <= 1'b0;
      busy          <= 1'b0;
      no_channel    <= 1'b0;
    end else begin
      state         <= state_next;
      ptr           <= ptr_next;
      output_select <= sel_next;
      rst_ptr       <= rst_ptr_next;
      settle_cnt    <= settle_next;
      orbit_cnt     <= orbit_next;
      switch_count  <= swc_next;
      mux_hold      <= hold_next;
      busy          <= busy_next;
      no_channel    <= no_ch_next;
    end
  end

  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    sel_next     = output_select;
    rst_ptr_next = rst_ptr;
    settle_next  = settle_cnt;
    orbit_next   = orbit_cnt;
    swc_next     = switch_count;
    if (!enable) begin
      state_next = IDLE;
    end else if (fc_linkReset && state != IDLE) begin
      rst_ptr_next = 1'b1;
      state_next   = DRAIN;
    end else begin
      case (state)
        IDLE: begin
          if (em != 16'd0) begin
            rst_ptr_next = 1'b1;
            state_next   = DRAIN;
          end
        end
        DRAIN: begin
          if (em == 16'd0) begin
            state_next = IDLE;
          end else if (!(mux_out_tvalid && !mux_out_tready)) begin
            ptr_next     = nxt_ch;
            sel_next     = nxt_ch;
            rst_ptr_next = 1'b0;
            swc_next     = switch_count + 16'd1;
            settle_next  = settle_cycles;
            state_next   = SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            orbit_next = '0;
            state_next = DWELL;
          end else begin
            settle_next = settle_cnt - S_ONE;
          end
        end
        DWELL: begin
          if (!em[ptr]) begin
            state_next = DRAIN;
          end else if (fc_orbitSync) begin
            if (dwell_orbits != '0 && orbit_cnt == dwell_orbits - D_ONE)
              state_next = DRAIN;
            else
              orbit_next = orbit_cnt + D_ONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Status flags are registered from the next-state decode.
  always_comb begin
    hold_next  = (state_next == SETTLE);
    busy_next  = (state_next != IDLE);
    no_ch_next = enable && (em == 16'd0);
  end

endmodule
